motion_cmd_sequencer: RTL and testbench

//  Command scheduler in front of StepperCtrlXY. Buffers relative XY moves from the plotter command

---
 rtl/motion_cmd_sequencer_if.sv | 13 +
 rtl/motion_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_motion_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motion_cmd_sequencer_if.sv
// rtl/motion_cmd_sequencer_if.sv - relative-move command stream between plotter path and sequencer
interface motion_cmd_sequencer_if #(
  parameter int COUNT_BITS_X = 8,
  parameter int COUNT_BITS_Y = 8
) ();
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic signed [COUNT_BITS_X-1:0] cmd_dx;
  logic signed [COUNT_BITS_Y-1:0] cmd_dy;

  modport master (output cmd_valid, output cmd_dx, output cmd_dy, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dx, input cmd_dy, output cmd_ready);
endinterface

// File: rtl/motion_cmd_sequencer.sv
// rtl/motion_cmd_sequencer.sv - FIFO-buffered XY move launcher with position tracking
// Optional workspace clamping is compiled in with SOFT_LIMIT_EN.
module motion_cmd_sequencer #(
  parameter int COUNT_BITS_X = 8,
  parameter int COUNT_BITS_Y = 8,
  parameter int POS_BITS     = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int X_MAX        = 200,
  parameter int Y_MAX        = 200
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic                              abort,
  motion_cmd_sequencer_if.slave             cmd,
  output logic                              trigger,
  output logic signed [COUNT_BITS_X-1:0]    num_steps_x,
  output logic signed [COUNT_BITS_Y-1:0]    num_steps_y,
  input  logic                              stepper_done,
  output logic signed [POS_BITS-1:0]        pos_x,
  output logic signed [POS_BITS-1:0]        pos_y,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              clamped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 || X_MAX < 0 || Y_MAX < 0) begin : g_bad_param
    $error("motion_cmd_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT_DONE} state_t;

  logic signed [COUNT_BITS_X-1:0] fifo_dx_q [FIFO_DEPTH];
  logic signed [COUNT_BITS_Y-1:0] fifo_dy_q [FIFO_DEPTH];
  logic [CW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                  count;
  logic                           full, empty, push, pop;

  state_t                         state_q;
  logic                           trigger_q, clamped_q;
  logic signed [COUNT_BITS_X-1:0] steps_x_q;
  logic signed [COUNT_BITS_Y-1:0] steps_y_q;
  logic signed [POS_BITS-1:0]     pos_x_q, pos_y_q;

  logic signed [COUNT_BITS_X-1:0] head_dx, issue_dx;
  logic signed [COUNT_BITS_Y-1:0] head_dy, issue_dy;
  logic                           clamp_hit;

  assign count         = wr_ptr_q - rd_ptr_q;
  assign full          = (count == CW'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign cmd.cmd_ready = !full && !abort;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state_q == S_IDLE) && !empty && !abort;
  assign head_dx       = fifo_dx_q[rd_ptr_q[AW-1:0]];
  assign head_dy       = fifo_dy_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dx_q[wr_ptr_q[AW-1:0]] <= cmd.cmd_dx;
      fifo_dy_q[wr_ptr_q[AW-1:0]] <= cmd.cmd_dy;
    end
  end

  // Abort and push are mutually exclusive, so flushing to the pre-edge write pointer is exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (abort) rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef SOFT_LIMIT_EN
  localparam int TW = POS_BITS + 2;
  logic signed [TW-1:0] tgt_x, tgt_y, lim_x, lim_y;

  always_comb begin
    tgt_x = TW'(pos_x_q) + TW'(head_dx);
    tgt_y = TW'(pos_y_q) + TW'(head_dy);
    lim_x = tgt_x;
    lim_y = tgt_y;
    if (tgt_x < 0) lim_x = '0;
    else if (tgt_x > TW'(X_MAX)) lim_x = TW'(X_MAX);
    if (tgt_y < 0) lim_y = '0;
    else if (tgt_y > TW'(Y_MAX)) lim_y = TW'(Y_MAX);
    issue_dx  = COUNT_BITS_X'(lim_x - TW'(pos_x_q));
    issue_dy  = COUNT_BITS_Y'(lim_y - TW'(pos_y_q));
    clamp_hit = (lim_x != tgt_x) || (lim_y != tgt_y);
  end
`else
  assign issue_dx  = head_dx;
  assign issue_dy  = head_dy;
  assign clamp_hit = 1'b0;
`endif

  // SETTLE burns one clk_en so the previous move's stale done is never taken as completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      trigger_q <= 1'b0;
      clamped_q <= 1'b0;
      steps_x_q <= '0;
      steps_y_q <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
    end else begin
      clamped_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            clamped_q <= clamp_hit;
            if (issue_dx != '0 || issue_dy != '0) begin
              steps_x_q <= issue_dx;
              steps_y_q <= issue_dy;
              trigger_q <= 1'b1;
              state_q   <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (clk_en) begin
            trigger_q <= 1'b0;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (clk_en) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (clk_en && stepper_done) begin
            pos_x_q <= pos_x_q + POS_BITS'(steps_x_q);
            pos_y_q <= pos_y_q + POS_BITS'(steps_y_q);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trigger     = trigger_q;
  assign num_steps_x = steps_x_q;
  assign num_steps_y = steps_y_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign busy        = (state_q != S_IDLE) || !empty;
  assign fifo_count  = count;
  assign clamped     = clamped_q;
endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// tb/tb_motion_cmd_sequencer.sv - directed and random checks of motion_cmd_sequencer against a move-list model
module tb_motion_cmd_sequencer;
  localparam int XMAX = 200;
  localparam int YMAX = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;
  int   en_mode = 0;

  logic              trigger, stepper_done, busy, clamped;
  logic signed [7:0]  num_steps_x, num_steps_y;
  logic signed [15:0] pos_x, pos_y;
  logic [2:0]         fifo_count;

  motion_cmd_sequencer_if #(.COUNT_BITS_X(8), .COUNT_BITS_Y(8)) ifc ();

  motion_cmd_sequencer #(
    .COUNT_BITS_X(8), .COUNT_BITS_Y(8), .POS_BITS(16), .FIFO_DEPTH(4), .X_MAX(XMAX), .Y_MAX(YMAX)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .abort(abort), .cmd(ifc),
    .trigger(trigger), .num_steps_x(num_steps_x), .num_steps_y(num_steps_y),
    .stepper_done(stepper_done), .pos_x(pos_x), .pos_y(pos_y), .busy(busy),
    .fifo_count(fifo_count), .clamped(clamped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) clk_en = (en_mode == 2) ? 1'($urandom_range(0, 1)) : (en_mode == 1);

  // Stub stepper: done drops on the launch clk_en, rises after max(|dx|,|dy|) further clk_en cycles.
  int stub_cnt;
  always @(posedge clk) begin
    if (reset) begin
      stepper_done <= 1'b1;
      stub_cnt     <= 0;
    end else if (clk_en) begin
      if (trigger) begin
        stepper_done <= 1'b0;
        stub_cnt     <= (abs8(num_steps_x) > abs8(num_steps_y)) ? abs8(num_steps_x) : abs8(num_steps_y);
      end else if (!stall && stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) stepper_done <= 1'b1;
      end
    end
  end

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int clamp_cnt = 0;
  always @(posedge clk) begin
    if (!reset && clk_en && trigger) obs_q.push_back({num_steps_x, num_steps_y});
    if (clamped) clamp_cnt++;
  end

  int checks = 0;
  int errors = 0;
  int m_px, m_py, m_clamps;

  function automatic int abs8(input logic signed [7:0] v);
    return (v < 0) ? -int'(v) : int'(v);
  endfunction

  // Reference: absolute target per command, optionally clamped; zero net moves issue nothing.
  function automatic void model_apply(input int dx, input int dy);
    int tx, ty, sx, sy;
    tx = m_px + dx;
    ty = m_py + dy;
`ifdef SOFT_LIMIT_EN
    if (tx < 0) tx = 0;
    if (tx > XMAX) tx = XMAX;
    if (ty < 0) ty = 0;
    if (ty > YMAX) ty = YMAX;
    if (tx != m_px + dx || ty != m_py + dy) m_clamps++;
`endif
    sx = tx - m_px;
    sy = ty - m_py;
    if (sx != 0 || sy != 0) begin
      exp_q.push_back({8'(sx), 8'(sy)});
      m_px = tx;
      m_py = ty;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    abort = 1'b0;
    stall = 1'b0;
    ifc.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_px = 0;
    m_py = 0;
    m_clamps = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic push(input int dx, input int dy, input bit apply);
    int k;
    k = 0;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_dx = 8'(dx);
    ifc.cmd_dy = 8'(dy);
    #1;
    while (ifc.cmd_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("push_ready", 32'(ifc.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    if (apply) model_apply(dx, dy);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 20000) begin
      tick();
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic compare_issued(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_move%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_pos_x"}, pos_x, 16'(m_px));
    check({tag, "_pos_y"}, pos_y, 16'(m_py));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int c0, cc0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_dx = '0;
    ifc.cmd_dy = '0;

    // Reset state and single-move latency with clk_en held low.
    en_mode = 0;
    do_reset();
    #1;
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_steps", {num_steps_x, num_steps_y}, 16'h0000);
    check("rst_pos", {pos_x, pos_y}, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_clamped", 32'(clamped), 32'd0);
    check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    push(2, 3, 1);
    check("lat_n_trigger", 32'(trigger), 32'd0);
    check("lat_n_count", 32'(fifo_count), 32'd1);
    tick();
    check("lat_n1_trigger", 32'(trigger), 32'd1);
    check("lat_n1_count", 32'(fifo_count), 32'd0);
    check("lat_n1_steps", {num_steps_x, num_steps_y}, 16'h0203);
    tick();
    check("launch_hold", 32'(trigger), 32'd1);
    en_mode = 1;
    wait_idle("t1_idle");
    check("t1_trigger_off", 32'(trigger), 32'd0);
    check("t1_pos", {pos_x, pos_y}, {16'sd2, 16'sd3});
    compare_issued("t1");

    // Full FIFO while the stepper stalls, then in-order drain.
    do_reset();
    en_mode = 1;
    stall = 1'b1;
    push(5, 5, 1);
    repeat (3) tick();
    push(1, 2, 1);
    push(-2, 1, 1);
    push(3, -3, 1);
    push(0, 4, 1);
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_dx = 8'sd7;
    ifc.cmd_dy = 8'sd7;
    #1;
    check("full_ready", 32'(ifc.cmd_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    ifc.cmd_valid = 1'b0;
    stall = 1'b0;
    wait_idle("t2_idle");
    compare_issued("t2");

    // Null move is skipped.
    do_reset();
    en_mode = 1;
    push(0, 0, 1);
    push(1, -1, 1);
    wait_idle("t3_idle");
    compare_issued("t3");

    // Abort flushes the queue while the first move finishes.
    do_reset();
    en_mode = 1;
    push(3, 2, 1);
    push(4, 4, 0);
    push(5, 1, 0);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_ready", 32'(ifc.cmd_ready), 32'd0);
    tick();
    check("abort_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    wait_idle("t4_idle");
    repeat (5) tick();
    compare_issued("t4");

    // Random moves with random clk_en.
    do_reset();
    en_mode = 2;
    cc0 = clamp_cnt;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) push(0, 0, 1);
      else push(int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 12)) - 6, 1);
    end
    wait_idle("rnd_idle");
    tick();
    compare_issued("rnd");
    check("rnd_clamps", clamp_cnt - cc0, m_clamps);

`ifdef SOFT_LIMIT_EN
    // Workspace clamp: negative X target pinned to 0, then a fully clamped move is dropped.
    do_reset();
    en_mode = 1;
    c0 = clamp_cnt;
    push(-7, 4, 1);
    wait_idle("t6_idle");
    tick();
    check("t6_clamp_pulse", clamp_cnt - c0, 1);
    check("t6_pos", {pos_x, pos_y}, {16'sd0, 16'sd4});
    compare_issued("t6");
    push(-3, 0, 1);
    wait_idle("t6b_idle");
    tick();
    check("t6b_clamp_pulse", clamp_cnt - c0, 2);
    compare_issued("t6b");
`else
    // Position wraps at the top of the signed range.
    do_reset();
    en_mode = 1;
    c0 = 0;
    cc0 = clamp_cnt;
    for (int i = 0; i < 258; i++) push(127, 0, 1);
    push(1, 0, 1);
    wait_idle("t5_idle");
    check("t5_pos_max", pos_x, 16'sh7fff);
    compare_issued("t5");
    push(1, 0, 1);
    wait_idle("t5b_idle");
    check("t5_pos_wrap", pos_x, 16'sh8000);
    compare_issued("t5b");
    check("t5_no_clamp", clamp_cnt - cc0, c0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
